pulse_train_tx: RTL and testbench
=================================

# pulse_train_tx

Transmit side of the photonic-switch trigger path. Generates the cascaded strobe pattern that the switch receivers consume: a primary strobe every (TC_A+1) enabled cycles and a secondary strobe train in alternate primary periods. Terminal counts are loaded at runtime over a valid/ready configuration handshake. Sits between the control register interface and the per-switch receivers.

## Interface
Parameters:
- W_A, 5, width of primary counter and its terminal count
- W_B, 5, width of secondary counter and its terminal count
- DEF_TC_A, 24, primary terminal count after reset
- DEF_TC_B, 7, secondary terminal count after reset

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  run request; high starts or continues generation
- cfg_valid  in  1  new terminal counts offered
- cfg_ready  out  1  shadow slot empty; a config can be accepted
- cfg_tc_a  in  W_A  offered primary terminal count
- cfg_tc_b  in  W_B  offered secondary terminal count
- strobe_a  out  1  one-cycle primary strobe
- strobe_b  out  1  one-cycle secondary strobe
- gate_b  out  1  secondary window; toggles on every strobe_a
- busy  out  1  FSM not in IDLE
- cnt_a  out  W_A  primary counter value
- cnt_b  out  W_B  secondary counter value

## Operation
- FSM states: IDLE, RUN, STOP.
  - IDLE -> RUN when en=1. In IDLE, cnt_a, cnt_b, gate_b, strobes are 0.
  - RUN -> STOP when en=0; STOP -> IDLE on the cycle cnt_a==tc_a (that period's strobe_a still issues). STOP -> RUN if en returns to 1 before the period completes.
- Primary: in RUN/STOP cnt_a increments each cycle, wraps tc_a -> 0. strobe_a = (state!=IDLE) && cnt_a==tc_a.
- gate_b toggles on each strobe_a cycle (takes effect next cycle).
- Secondary: cnt_b increments each cycle gate_b=1, wraps tc_b -> 0; holds value while gate_b=0. strobe_b = gate_b && cnt_b==tc_b.
- Active tc_a/tc_b: reset to DEF_TC_A/DEF_TC_B.
- Config handshake: transfer when cfg_valid && cfg_ready. In IDLE, transfer writes active tcs directly (cfg_ready=1). In RUN/STOP, transfer writes a shadow slot; cfg_ready=0 while shadow full. Shadow is copied to active tcs on a strobe_a cycle (new values govern the next period); shadow then empties, cfg_ready=1 next cycle.
- Simultaneous transfer and strobe_a in RUN: the transferring config goes to shadow, applied at the next strobe_a.
- tc_a=0: strobe_a every cycle, gate_b toggles every cycle. tc_b=0: strobe_b every gated cycle.
- Counters compare with ==, unsigned; no arithmetic beyond +1 mod 2^W.

## Timing
- Reset values: cfg_ready=1, strobes=0, gate_b=0, busy=0, cnt_a=0, cnt_b=0; shadow empty; FSM IDLE.
- en sampled at clk; first RUN cycle has cnt_a=0, busy=1.
- Strobes decoded from registered counters/state; asserted same cycle counter equals tc, never longer than one cycle (except tc=0 cases).
- Primary period = tc_a+1 cycles; secondary window length = tc_a+1 cycles; strobe_b count per window = floor((tc_a+1 + carried cnt_b)/(tc_b+1)).
- Reset mid-operation: immediate return to reset values; pending shadow config lost.

## Configuration
- PULSE_TRAIN_TX_EVCNT_EN defined: extra output ev_count out 16, counts strobe_b cycles, saturates at 16'hFFFF, cleared on reset and on IDLE->RUN.
- Undefined: port and counter absent; other behaviour identical.

## Structure
- Shared package: FSM state enum (IDLE, RUN, STOP), DEF_TC_A/DEF_TC_B defaults, event-counter width constant.
- One sub-module: tc_counter (generic wrap-at-terminal counter with enable, clear, hit output), instantiated for primary and secondary.

## Test plan
- Reset, en=1, defaults: strobe_a at cycles 24, 49, 74 after start; gate_b high cycles 25–49; strobe_b at cycles 32, 40, 48.
- In RUN, offer tc_a=9, tc_b=3 mid-period: cfg_ready drops next cycle; period after next strobe_a is 10 cycles; cfg_ready returns after that strobe_a.
- Second cfg_valid while shadow full: held off (cfg_ready=0) until shadow applies; no config lost or overwritten.
- Drop en at cnt_a=10 (tc_a=24): strobe_a still at cnt_a=24, then busy=0 and counters 0 next cycle; re-raise en at cnt_a=15 instead: stays RUN, no gap.
- tc_a=0, tc_b=0: strobe_a every cycle, gate_b alternates, strobe_b on every gated cycle.
- Assert reset mid-RUN with shadow pending: all outputs at reset values asynchronously; after release, defaults 24/7 active; with PULSE_TRAIN_TX_EVCNT_EN, ev_count=0.

Source files
------------

// File: rtl/pulse_train_tx_pkg.sv
// Shared types and constants for the pulse_train_tx strobe generator.
// Holds the FSM state encoding, power-up terminal counts and event counter width.
package pulse_train_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int PTT_DEF_TC_A = 24;
  localparam int PTT_DEF_TC_B = 7;
  localparam int EV_CNT_W     = 16;

endpackage

// File: rtl/pulse_train_tx_tc_counter.sv
// Generic wrap-at-terminal counter: counts 0..tc while enabled, clear has priority.
// hit is decoded from the registered count so it aligns with the counter value.
module tc_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] tc,
  output logic [W-1:0] cnt,
  output logic         hit
);

  logic [W-1:0] cnt_r;

  // Counter register: clear wins over enable, wraps to zero at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == tc) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end
  end

  assign cnt = cnt_r;
  assign hit = (cnt_r == tc);

endmodule

// File: rtl/pulse_train_tx.sv
// Cascaded primary/secondary strobe generator with runtime terminal counts.
// Optional saturating strobe_b event counter enabled by PULSE_TRAIN_TX_EVCNT_EN.
module pulse_train_tx
  import pulse_train_tx_pkg::*;
#(
  parameter int W_A      = 5,
  parameter int W_B      = 5,
  parameter int DEF_TC_A = PTT_DEF_TC_A,
  parameter int DEF_TC_B = PTT_DEF_TC_B
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [W_A-1:0] cfg_tc_a,
  input  logic [W_B-1:0] cfg_tc_b,
  output logic           strobe_a,
  output logic           strobe_b,
  output logic           gate_b,
  output logic           busy,
  output logic [W_A-1:0] cnt_a,
  output logic [W_B-1:0] cnt_b
`ifdef PULSE_TRAIN_TX_EVCNT_EN
  ,
  output logic [EV_CNT_W-1:0] ev_count
`endif
);

  state_t         state_r;
  state_t         state_nxt_s;
  logic [W_A-1:0] tc_a_r;
  logic [W_B-1:0] tc_b_r;
  logic [W_A-1:0] shd_a_r;
  logic [W_B-1:0] shd_b_r;
  logic           shd_full_r;
  logic           gate_r;
  logic           run_s;
  logic           clr_s;
  logic           hit_a_s;
  logic           hit_b_s;
  logic           xfer_s;

  assign run_s    = (state_r != ST_IDLE);
  assign clr_s    = (state_nxt_s == ST_IDLE);
  assign xfer_s   = cfg_valid && !shd_full_r;
  assign strobe_a = run_s && hit_a_s;
  assign strobe_b = gate_r && hit_b_s;
  assign gate_b   = gate_r;
  assign busy     = run_s;
  assign cfg_ready = !shd_full_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a stop request only retires at the end of the current period
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STOP: begin
        if (en) begin
          state_nxt_s = ST_RUN;
        end else if (hit_a_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Secondary window flips on every primary strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_r <= 1'b0;
    end else if (clr_s) begin
      gate_r <= 1'b0;
    end else if (strobe_a) begin
      gate_r <= !gate_r;
    end
  end

  // Terminal-count registers: direct load when idle, otherwise staged in the shadow slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_a_r     <= W_A'(DEF_TC_A);
      tc_b_r     <= W_B'(DEF_TC_B);
      shd_a_r    <= '0;
      shd_b_r    <= '0;
      shd_full_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      // a config staged on the final strobe of a stop still lands here
      if (shd_full_r) begin
        tc_a_r     <= shd_a_r;
        tc_b_r     <= shd_b_r;
        shd_full_r <= 1'b0;
      end else if (xfer_s) begin
        tc_a_r <= cfg_tc_a;
        tc_b_r <= cfg_tc_b;
      end
    end else begin
      if (strobe_a && shd_full_r) begin
        tc_a_r     <= shd_a_r;
        tc_b_r     <= shd_b_r;
        shd_full_r <= 1'b0;
      end else if (xfer_s) begin
        shd_a_r    <= cfg_tc_a;
        shd_b_r    <= cfg_tc_b;
        shd_full_r <= 1'b1;
      end
    end
  end

  tc_counter #(.W(W_A)) u_cnt_a (
    .clk   (clk),
    .rst_n (reset),
    .en    (run_s),
    .clr   (clr_s),
    .tc    (tc_a_r),
    .cnt   (cnt_a),
    .hit   (hit_a_s)
  );

  tc_counter #(.W(W_B)) u_cnt_b (
    .clk   (clk),
    .rst_n (reset),
    .en    (gate_r),
    .clr   (clr_s),
    .tc    (tc_b_r),
    .cnt   (cnt_b),
    .hit   (hit_b_s)
  );

`ifdef PULSE_TRAIN_TX_EVCNT_EN
  logic [EV_CNT_W-1:0] ev_cnt_r;

  // Saturating strobe_b event counter, restarted on each IDLE->RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_RUN)) begin
      ev_cnt_r <= '0;
    end else if (strobe_b && (ev_cnt_r != {EV_CNT_W{1'b1}})) begin
      ev_cnt_r <= ev_cnt_r + EV_CNT_W'(1);
    end
  end

  assign ev_count = ev_cnt_r;
`endif

endmodule

// File: tb/tb_pulse_train_tx.sv
// Self-checking bench for pulse_train_tx: period-level reference model plus
// directed scenarios with hand-computed strobe positions and handshake timing.
module tb_pulse_train_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [4:0] cfg_tc_a = 5'd0;
  logic [4:0] cfg_tc_b = 5'd0;
  logic       strobe_a, strobe_b, gate_b, busy;
  logic [4:0] cnt_a, cnt_b;
`ifdef PULSE_TRAIN_TX_EVCNT_EN
  logic [15:0] ev_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_train_tx dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_tc_a  (cfg_tc_a),
    .cfg_tc_b  (cfg_tc_b),
    .strobe_a  (strobe_a),
    .strobe_b  (strobe_b),
    .gate_b    (gate_b),
    .busy      (busy),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
`ifdef PULSE_TRAIN_TX_EVCNT_EN
    ,
    .ev_count  (ev_count)
`endif
  );

  // Reference model: position in period, window flag, secondary count, staged config
  typedef struct packed {
    bit busy;
    bit stopping;
    int pos;
    bit gate;
    int cb;
    int tca;
    int tcb;
    bit shd;
    int shd_a;
    int shd_b;
    int ev;
  } mst_t;

  mst_t m;

  function automatic mst_t mreset();
    mst_t r;
    r = '0;
    r.tca = 24;
    r.tcb = 7;
    return r;
  endfunction

  function automatic mst_t step(mst_t s, bit en_i, bit v, int ta, int tb);
    mst_t n;
    bit sa, sb;
    n  = s;
    sa = s.busy && (s.pos == s.tca);
    sb = s.gate && (s.cb == s.tcb);
    if (!s.busy && s.shd) begin
      n.tca = s.shd_a; n.tcb = s.shd_b; n.shd = 1'b0;
    end else if (!s.busy && v) begin
      n.tca = ta; n.tcb = tb;
    end else if (s.busy && sa && s.shd) begin
      n.tca = s.shd_a; n.tcb = s.shd_b; n.shd = 1'b0;
    end else if (s.busy && v && !s.shd) begin
      n.shd = 1'b1; n.shd_a = ta; n.shd_b = tb;
    end
    if (!s.busy && en_i) n.ev = 0;
    else if (sb && s.ev < 65535) n.ev = s.ev + 1;
    if (!s.busy) begin
      n.busy = en_i;
      n.stopping = 1'b0;
    end else if (s.stopping && !en_i && sa) begin
      n.busy = 1'b0; n.stopping = 1'b0; n.pos = 0; n.gate = 1'b0; n.cb = 0;
    end else begin
      n.stopping = !en_i;
      n.pos = sa ? 0 : (s.pos + 1) % 32;
      if (sa) n.gate = !s.gate;
      if (s.gate) n.cb = sb ? 0 : (s.cb + 1) % 32;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mreset();
    else        m <= step(m, en, cfg_valid, int'(cfg_tc_a), int'(cfg_tc_b));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m_strobe_a", strobe_a, m.busy && (m.pos == m.tca));
    chk("m_strobe_b", strobe_b, m.gate && (m.cb == m.tcb));
    chk("m_gate_b", gate_b, m.gate);
    chk("m_busy", busy, m.busy);
    chk("m_cnt_a", cnt_a, m.pos);
    chk("m_cnt_b", cnt_b, m.cb);
    chk("m_cfg_ready", cfg_ready, !m.shd);
`ifdef PULSE_TRAIN_TX_EVCNT_EN
    chk("m_ev_count", ev_count, m.ev);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_sa(input int lim, output int k);
    k = 0;
    while (!strobe_a && k < lim) begin
      cyc();
      k++;
    end
  endtask

  task automatic wait_idle(input int lim, output int k);
    k = 0;
    while (busy && k < lim) begin
      cyc();
      k++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobe_a"}, strobe_a, 0);
    chk({tag, "_strobe_b"}, strobe_b, 0);
    chk({tag, "_gate_b"}, gate_b, 0);
    chk({tag, "_cnt_a"}, cnt_a, 0);
    chk({tag, "_cnt_b"}, cnt_b, 0);
`ifdef PULSE_TRAIN_TX_EVCNT_EN
    chk({tag, "_ev_count"}, ev_count, 0);
`endif
  endtask

  initial begin
    int k;
    // Reset state
    cyc(); cyc();
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Default counts 24/7
    en = 1'b1;
    cyc();
    for (int t = 0; t <= 60; t++) begin
      chk("def_sa", strobe_a, (t == 24) || (t == 49));
      chk("def_sb", strobe_b, (t == 32) || (t == 40) || (t == 48));
      chk("def_gate", gate_b, (t >= 25) && (t <= 49));
      chk("def_cnt_a", cnt_a, t % 25);
      cyc();
    end

    // Mid-period config 9/3, then a second offer held off while the shadow is full
    cfg_valid = 1'b1; cfg_tc_a = 5'd9; cfg_tc_b = 5'd3;
    cyc();
    chk("cfg1_ready_low", cfg_ready, 0);
    cfg_tc_a = 5'd5; cfg_tc_b = 5'd2;
    wait_sa(30, k);
    chk("cfg1_wait", k, 12);
    chk("cfg1_ready_hold", cfg_ready, 0);
    chk("cfg1_cnt_a", cnt_a, 24);
    cyc();
    chk("cfg1_ready_back", cfg_ready, 1);
    cyc();
    cfg_valid = 1'b0;
    chk("cfg2_ready_low", cfg_ready, 0);
    wait_sa(30, k);
    chk("period10", k, 8);
    cyc();
    chk("cfg2_ready_back", cfg_ready, 1);
    wait_sa(30, k);
    chk("period6", k, 5);

    // Stop request finishes the current period
    en = 1'b0;
    wait_idle(40, k);
    chk("stop_idle_wait", k, 7);
    chk("stop_cnt_a", cnt_a, 0);
    cfg_valid = 1'b1; cfg_tc_a = 5'd24; cfg_tc_b = 5'd7;
    cyc();
    cfg_valid = 1'b0;
    chk("idle_cfg_ready", cfg_ready, 1);
    en = 1'b1;
    cyc();
    repeat (10) cyc();
    chk("drop_cnt_a", cnt_a, 10);
    en = 1'b0;
    wait_sa(30, k);
    chk("drop_wait", k, 14);
    chk("drop_busy", busy, 1);
    cyc();
    chk("drop_busy_off", busy, 0);
    chk("drop_cnt_a0", cnt_a, 0);
    chk("drop_gate", gate_b, 0);
    chk("drop_cnt_b", cnt_b, 0);

    // Re-raise en before the period completes
    en = 1'b1;
    cyc();
    repeat (10) cyc();
    en = 1'b0;
    repeat (5) cyc();
    chk("reraise_cnt_a", cnt_a, 15);
    chk("reraise_busy", busy, 1);
    en = 1'b1;
    wait_sa(30, k);
    chk("reraise_wait", k, 9);
    cyc();
    chk("reraise_busy2", busy, 1);
    chk("reraise_cnt_a0", cnt_a, 0);
    chk("reraise_gate", gate_b, 1);

    // tc_a = 0, tc_b = 0
    en = 1'b0;
    wait_idle(60, k);
    chk("zero_idle_wait", k, 25);
    cfg_valid = 1'b1; cfg_tc_a = 5'd0; cfg_tc_b = 5'd0;
    cyc();
    cfg_valid = 1'b0;
    en = 1'b1;
    cyc();
    for (int t = 0; t < 8; t++) begin
      chk("zero_sa", strobe_a, 1);
      chk("zero_gate", gate_b, t % 2);
      chk("zero_sb", strobe_b, t % 2);
      cyc();
    end

    // Reset mid-run with a staged config
    cfg_valid = 1'b1; cfg_tc_a = 5'd12; cfg_tc_b = 5'd4;
    cyc();
    cfg_valid = 1'b0;
    chk("pend_ready", cfg_ready, 0);
    #2;
    reset = 1'b0;
    en = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    check_all();
    @(negedge clk);
    reset = 1'b1;
    cyc();
    en = 1'b1;
    cyc();
    wait_sa(40, k);
    chk("post_rst_period", k, 24);
    cyc();
    wait_sa(40, k);
    chk("post_rst_period2", k, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
